// File: rtl/run_ctrl_pkg.sv
// Shared types and default configuration for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int unsigned DEF_NUM_CORES       = 1;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 2;
  localparam int unsigned DEF_MAX_RUN_CYCLES  = 50;
  localparam int unsigned DEF_CNT_W           = 32;

  // Bits needed to represent max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/run_ctrl_sat_cnt.sv
// Up-counter with synchronous clear and enable that sticks at all ones.
module run_ctrl_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds cores in reset, runs them until all halt or the cycle budget expires.
// Optional RUN_CTRL_STAGGER_EN releases core i from reset i cycles after RUN entry.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES       = DEF_NUM_CORES,
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned MAX_RUN_CYCLES  = DEF_MAX_RUN_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] halt,
  output logic [NUM_CORES-1:0] core_rst,
  output logic                 running,
  output logic                 done,
  output logic                 timed_out,
  output logic [NUM_CORES-1:0] halted,
  output logic [CNT_W-1:0]     cycle_count
);

`ifdef RUN_CTRL_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  localparam int unsigned          HOLD_W    = cnt_width(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     RUN_LAST  = CNT_W'(MAX_RUN_CYCLES - 1);
  // Core 0 is released on RUN entry; with staggering the rest follow one per cycle.
  localparam logic [NUM_CORES-1:0] RUN_ENTRY_RST = STAGGER ? ~NUM_CORES'(1) : '0;

  state_e                state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  enter_reset;
  logic [NUM_CORES-1:0]  halt_hit;
  logic [NUM_CORES-1:0]  run_rst_next;

  assign enter_reset  = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                  (state == ST_TIMEOUT));
  assign halt_hit     = halted | (halt & ~core_rst);
  assign run_rst_next = STAGGER ? (core_rst << 1) : '0;

  run_ctrl_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (enter_reset),
    .en  (state == ST_RUN),
    .q   (cycle_count)
  );

  run_ctrl_sat_cnt #(.W(HOLD_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (enter_reset),
    .en  (state == ST_RESET),
    .q   (hold_cnt)
  );

  // State register with registered state decodes, core resets and halt record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      core_rst  <= '1;
      halted    <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RESET;
            halted <= '0;
          end
        end
        ST_RESET: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= ST_RUN;
            running  <= 1'b1;
            core_rst <= RUN_ENTRY_RST;
          end
        end
        ST_RUN: begin
          halted <= halt_hit;
          if (&halt_hit) begin
            state    <= ST_DONE;
            running  <= 1'b0;
            done     <= 1'b1;
            core_rst <= '1;
          end else if (cycle_count == RUN_LAST) begin
            state     <= ST_TIMEOUT;
            running   <= 1'b0;
            timed_out <= 1'b1;
            core_rst  <= '1;
          end else begin
            core_rst <= run_rst_next;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          if (start) begin
            state     <= ST_RESET;
            halted    <= '0;
            done      <= 1'b0;
            timed_out <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          core_rst  <= '1;
          running   <= 1'b0;
          done      <= 1'b0;
          timed_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized scoreboard bench for run_ctrl; honours RUN_CTRL_STAGGER_EN when defined.
module tb_run_ctrl;

  localparam int unsigned NC   = 3;
  localparam int unsigned HOLD = 2;
  localparam int unsigned MAXC = 50;
  localparam int unsigned CW   = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NC-1:0] halt, core_rst, halted;
  logic          running, done, timed_out;
  logic [CW-1:0] cycle_count;

  run_ctrl #(
    .NUM_CORES(NC), .RST_HOLD_CYCLES(HOLD), .MAX_RUN_CYCLES(MAXC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .core_rst(core_rst),
    .running(running), .done(done), .timed_out(timed_out), .halted(halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    int unsigned   cnt;
    logic [NC-1:0] hmask;
  } exp_t;

  exp_t          sb[$];
  logic [NC-1:0] plan[MAXC];
  int            errors = 0;
  int            checks = 0;
  logic          prev_end = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Cores allowed to record a halt on RUN cycle k.
  function automatic logic [NC-1:0] eligible(input int k);
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) begin
`ifdef RUN_CTRL_STAGGER_EN
      m[i] = (k >= i);
`else
      m[i] = 1'b1;
`endif
    end
    return m;
  endfunction

  // Reference outcome of the current plan and the last RUN cycle it occupies.
  task automatic model(output exp_t e, output int end_k);
    logic [NC-1:0] h = '0;
    e.is_done = 1'b0;
    e.cnt     = MAXC;
    end_k     = MAXC - 1;
    for (int k = 0; k < MAXC; k++) begin
      h |= plan[k] & eligible(k);
      if (&h) begin
        e.is_done = 1'b1;
        e.cnt     = k + 1;
        end_k     = k;
        break;
      end
    end
    e.hmask = h;
  endtask

  // mode: 0 random, 1 all halt at cycle 10, 2 never halt, 3 all halt at 49, 4 all halt from entry
  task automatic do_run(input int mode, input bit chk_entry);
    exp_t        e;
    int          end_k, sp, rate;
    rate = $urandom_range(6, 150);
    for (int k = 0; k < MAXC; k++) begin
      case (mode)
        1:       plan[k] = (k == 10) ? '1 : '0;
        2:       plan[k] = '0;
        3:       plan[k] = (k == 49) ? '1 : '0;
        4:       plan[k] = '1;
        default: for (int i = 0; i < NC; i++) plan[k][i] = ($urandom_range(0, rate - 1) == 0);
      endcase
    end
    model(e, end_k);
    sb.push_back(e);
    sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, end_k)) : -1;
    @(negedge clk) start = 1'b1; halt = NC'($urandom);
    @(negedge clk) start = 1'b0; halt = NC'($urandom);
    if (chk_entry) begin
      check("reset_hold_core_rst_0", 64'(core_rst), 64'({NC{1'b1}}));
      check("reset_hold_running_0", 64'(running), 64'd0);
    end
    repeat (HOLD - 1) @(negedge clk) halt = NC'($urandom);
    if (chk_entry) begin
      check("reset_hold_core_rst_1", 64'(core_rst), 64'({NC{1'b1}}));
      check("reset_hold_count", 64'(cycle_count), 64'd0);
    end
    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      halt  = plan[k];
      start = (k == sp);
      if (chk_entry && k == 0) begin
        check("run_entry_running", 64'(running), 64'd1);
`ifdef RUN_CTRL_STAGGER_EN
        check("run_entry_core_rst", 64'(core_rst), 64'(~NC'(1)));
`else
        check("run_entry_core_rst", 64'(core_rst), 64'd0);
`endif
      end
    end
    @(negedge clk) start = 1'b0; halt = NC'($urandom);
    repeat (2) @(negedge clk) halt = NC'($urandom);
    check("run_completed", 64'(sb.size()), 64'd0);
    halt = '0;
  endtask

  // Monitor: pops the expected outcome whenever a run ends.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (done || timed_out) && !prev_end) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: got done=%0b timed_out=%0b expected no run end", done, timed_out);
        end else begin
          e = sb.pop_front();
          check("end_done", 64'(done), 64'(e.is_done));
          check("end_timed_out", 64'(timed_out), 64'(!e.is_done));
          check("end_cycle_count", 64'(cycle_count), 64'(e.cnt));
          check("end_halted", 64'(halted), 64'(e.hmask));
          check("end_core_rst", 64'(core_rst), 64'({NC{1'b1}}));
          check("end_running", 64'(running), 64'd0);
        end
      end
      prev_end = done || timed_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt = '0;
    repeat (2) @(negedge clk);
    check("rst_core_rst", 64'(core_rst), 64'({NC{1'b1}}));
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    check("rst_flags", 64'({running, done, timed_out}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start", 64'(running), 64'd0);

    do_run(1, 1'b1);
    do_run(2, 1'b0);
    do_run(3, 1'b0);
    do_run(4, 1'b0);
    for (int r = 0; r < 14; r++) do_run(0, 1'b0);

    // Abort mid-RUN with core 0 already halted.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (HOLD - 1) @(negedge clk);
    for (int k = 0; k < 5; k++) @(negedge clk) halt = NC'(1);
    @(negedge clk) halt = '0;
    check("pre_abort_running", 64'(running), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_core_rst", 64'(core_rst), 64'({NC{1'b1}}));
    check("abort_halted", 64'(halted), 64'd0);
    check("abort_count", 64'(cycle_count), 64'd0);
    check("abort_flags", 64'({running, done, timed_out}), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle", 64'({running, done, timed_out}), 64'd0);
    do_run(2, 1'b0);
    do_run(0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1: number of controlled cores (1..8).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 2: cycles core reset is held after start (>=1).
REQ-003 SHALL have parameter MAX_RUN_CYCLES, default 50: run-cycle budget before timeout (1..2^CNT_W-1).
REQ-004 SHALL have parameter CNT_W, default 32: cycle counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin a run.
REQ-008 SHALL have port halt, input, NUM_CORES: per-core halt indication (level or pulse).
REQ-009 SHALL have port core_rst, output, NUM_CORES: per-core active-high reset.
REQ-010 SHALL have port running, output, 1: high in RUN.
REQ-011 SHALL have port done, output, 1: high in DONE.
REQ-012 SHALL have port timed_out, output, 1: high in TIMEOUT.
REQ-013 SHALL have port halted, output, NUM_CORES: sticky per-core halt record.
REQ-014 SHALL have port cycle_count, output, CNT_W: RUN cycles elapsed in current or last run.

Function
REQ-015 SHALL implement states IDLE, RESET, RUN, DONE, TIMEOUT; running/done/timed_out are decodes of state, registered.
REQ-016 In IDLE, start SHALL move to RESET next cycle; otherwise stay.
REQ-017 Entering RESET SHALL clear halted and cycle_count to 0.
REQ-018 RESET SHALL last exactly RST_HOLD_CYCLES cycles with core_rst all ones, then enter RUN.
REQ-019 In RUN, cycle_count SHALL increment by 1 each cycle, saturating at all ones.
REQ-020 In RUN, halted[i] SHALL set when halt[i]=1 and core_rst[i]=0; it never clears until next RESET.
REQ-021 RUN SHALL go to DONE the cycle after halted (including same-cycle sets) becomes all ones.
REQ-022 RUN SHALL go to TIMEOUT when cycle_count reaches MAX_RUN_CYCLES-1 and not all cores halted; all-halted that same cycle SHALL give DONE.
REQ-023 In DONE and TIMEOUT, core_rst SHALL be all ones and cycle_count, halted SHALL hold.
REQ-024 start in DONE or TIMEOUT SHALL enter RESET (rerun); start in RESET or RUN SHALL be ignored.
REQ-025 halt inputs outside RUN SHALL be ignored.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, core_rst all ones, halted 0, cycle_count 0, running/done/timed_out 0.
REQ-027 rst asserted mid-RESET or mid-RUN SHALL abort the run with no recorded halts; release returns to IDLE awaiting start.

Configuration
REQ-028 Macro RUN_CTRL_STAGGER_EN defined: core_rst[i] SHALL deassert i cycles after RUN entry (core 0 at entry); budget still counts from RUN entry.
REQ-029 Macro RUN_CTRL_STAGGER_EN undefined: all core_rst bits SHALL deassert together on RUN entry.

Structure
REQ-030 Package run_ctrl_pkg SHALL hold the state enum (3-bit encoding) and default parameter constants.
REQ-031 A saturating counter sub-module run_ctrl_sat_cnt (width param, clear, enable) SHALL implement cycle_count and the reset-hold counter.

Verification
REQ-032 Defaults, rst high 2 cycles then low, start pulse -> core_rst high 2 cycles, running rises, core_rst 0.
REQ-033 Defaults, halt[0] at RUN cycle 10 -> halted=1, done=1 next cycle, cycle_count=11, core_rst=1.
REQ-034 Defaults, no halt -> timed_out=1 after 50 RUN cycles, cycle_count=50, halted=0.
REQ-035 Defaults, halt on RUN cycle 49 -> done=1, timed_out stays 0.
REQ-036 NUM_CORES=3 with RUN_CTRL_STAGGER_EN, halt all bits at RUN entry -> halted goes 001, 011, 111 over 3 cycles, then done.
REQ-037 rst pulse at RUN cycle 5 -> immediate IDLE, all outputs at reset values; new start runs full budget from 0.
